// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encodings and defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mux_scan_ctrl_pkg;

    // Default select width; N = 2**SEL_W mux inputs.
    localparam int SCAN_SEL_W_DEF = 4;

    // FSM state encodings (2-bit, legacy-compatible values).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan sequencer, the external mux and the downstream bit consumer.
// Latency: n/a (wires only).
// Backpressure: bit_valid/bit_ready handshake; a bit transfers when both are high.
//
// Signals:
//   sel       select driven to the mux (sequencer -> mux)
//   y_in      mux output Y (mux -> sequencer)
//   bit_out   sampled bit (sequencer -> consumer)
//   bit_valid bit_out holds a valid bit (sequencer -> consumer)
//   bit_ready consumer accepts bit_out (consumer -> sequencer)
interface mux_scan_ctrl_if #(
    parameter int SEL_W = 4
);
    logic [SEL_W-1:0] sel;
    logic             y_in;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;

    // Sequencer side.
    modport master (
        output sel,
        output bit_out,
        output bit_valid,
        input  y_in,
        input  bit_ready
    );

    // Mux/consumer side.
    modport slave (
        input  sel,
        input  bit_out,
        input  bit_valid,
        output y_in,
        output bit_ready
    );
endinterface

// File: rtl/mux_16x1.sv
// External 16:1 mux feeding the scan sequencer.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_a data inputs, i_sel select, o_y selected bit.
module mux_16x1 (
    input  logic [15:0] i_a,
    input  logic [3:0]  i_sel,
    output logic        o_y
);
    assign o_y = i_a[i_sel];
endmodule

// File: rtl/mux_scan_cnt.sv
// Load/step select counter for the scan sequencer; flags the last index of the walk.
// Latency: count updates one cycle after load/step; at_last is a decode of the register.
// Backpressure: none; holds its value whenever neither load nor step is asserted.
//
// Ports:
//   clk, rst_n  clock, async active-low reset (count -> 0)
//   i_load      load the first index (0 when counting up, N-1 when counting down)
//   i_step      advance one position in the walk direction
//   i_up        1: walk 0..N-1, 0: walk N-1..0
//   o_cnt       current index (registered)
//   o_at_last   current index is the final one of the walk
module mux_scan_cnt #(
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_up,
    output logic [SEL_W-1:0] o_cnt,
    output logic             o_at_last
);
    localparam logic [SEL_W-1:0] LP_MAX = '1;
    localparam logic [SEL_W-1:0] LP_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_up ? '0 : LP_MAX;
        end else if (i_step) begin
            // Caller never steps past the last index, so no wrap occurs within a scan.
            r_cnt <= i_up ? (r_cnt + LP_ONE) : (r_cnt - LP_ONE);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_at_last = i_up ? (r_cnt == LP_MAX) : (r_cnt == '0);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer around an external 2**SEL_W:1 mux: walks sel, samples Y, streams each bit out.
// Latency: 2 cycles per bit (SAMPLE + WAIT) plus downstream stall; done one cycle after last accept.
// Backpressure: bit_out/sel held stable in WAIT until bit_ready; no bit is dropped.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_start      begin one scan (only honoured in IDLE, and not together with i_abort)
//   i_abort      cancel scan in progress; partial captured word is kept
//   bus          master side of mux_scan_ctrl_if (sel, y_in, bit_out, bit_valid, bit_ready)
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse after the final bit is accepted
//   o_captured   rebuilt word; bit k = value sampled from mux input k
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SEL_W     = SCAN_SEL_W_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    mux_scan_ctrl_if.master       bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [(1<<SEL_W)-1:0] o_captured
);
    logic [1:0]             r_state;
    logic                   r_bit;
    logic                   r_vld;
    logic [(1<<SEL_W)-1:0]  r_cap;

    logic [SEL_W-1:0]       w_sel;
    logic                   w_at_last;
    logic                   w_load;
    logic                   w_step;

    // Load the first index on an accepted start; step only on a handshake that
    // is not the final one, so sel keeps the last index after the scan.
    assign w_load = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_step = (r_state == ST_WAIT) && !i_abort && bus.bit_ready && !w_at_last;

    mux_scan_cnt #(
        .SEL_W (SEL_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_up      (LSB_FIRST),
        .o_cnt     (w_sel),
        .o_at_last (w_at_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bit   <= 1'b0;
            r_vld   <= 1'b0;
            r_cap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_cap   <= '0;
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Abort wins over the sample: the in-flight bit is not captured.
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_bit        <= bus.y_in;
                        r_cap[w_sel] <= bus.y_in;
                        r_vld        <= 1'b1;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // bit_valid is always high here, so bit_ready alone completes the handshake.
                    if (i_abort) begin
                        r_vld   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (bus.bit_ready) begin
                        r_vld   <= 1'b0;
                        r_state <= w_at_last ? ST_DONE : ST_SAMPLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are register or register decodes: no path from y_in/bit_ready.
    assign bus.sel       = w_sel;
    assign bus.bit_out   = r_bit;
    assign bus.bit_valid = r_vld;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_captured    = r_cap;
endmodule
